// File: rtl/seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_pkg                                                |
// | Purpose : Shared types, op codes and helpers for the HLS op       |
// |           sequencer.                                             |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        START     = 3'd2,
        RUN       = 3'd3,
        SEND      = 3'd4,
        WAIT_TX   = 3'd5
    } state_t;

    localparam int unsigned OP_READ_A = 1;
    localparam int unsigned OP_READ_B = 2;
    localparam int unsigned OP_SUM    = 3;
    localparam int unsigned OP_AVG    = 4;
    localparam int unsigned OP_MAN    = 5;
    localparam int unsigned OP_EUC    = 6;

    // Ops that need the vector core (sum/avg/man/euc).
    function automatic logic is_compute_op(input logic [31:0] op);
        return (op >= OP_SUM) && (op <= OP_EUC);
    endfunction

    // Ops answered directly from the sequencer without touching the core.
    function automatic logic is_read_op(input logic [31:0] op);
        return (op == OP_READ_A) || (op == OP_READ_B);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_watchdog                                           |
// | Purpose : Cycle counter that flags a stuck state; restarts on    |
// |           every state change and holds at zero when disabled.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module seq_watchdog #(
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent in a watched state; saturate at the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i || !enable_i) begin
            cnt_q <= '0;
        end else if (cnt_q != C_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/hls_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hls_op_sequencer                                       |
// | Purpose : Sequences the HLS vector core (ap_ctrl_hs) between the |
// |           command decoder and UART TX, with a one-deep command   |
// |           slot, result capture and watchdog recovery.            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module hls_op_sequencer
    import seq_pkg::*;
#(
    parameter int RES_W       = 32,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic             vec_a_loaded,
    input  logic             vec_b_loaded,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_idle,
    input  logic             ap_done,
    input  logic             res_vld,
    input  logic [RES_W-1:0] res_data,
    output logic             tx_start,
    output logic [OP_W-1:0]  tx_op,
    output logic [RES_W-1:0] tx_data,
    input  logic             tx_done,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_noload,
    output logic             err_overrun
);
    state_t             state_q, state_d;
    logic [OP_W-1:0]    cur_op_q, cur_op_d;
    logic               pend_vld_q, pend_vld_d;
    logic [OP_W-1:0]    pend_op_q, pend_op_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               res_seen_q, res_seen_d;
    logic [RES_W-1:0]   tx_data_q, tx_data_d;
    logic [OP_W-1:0]    tx_op_q, tx_op_d;
    logic               a_ok_q, a_ok_d, b_ok_q, b_ok_d;
    logic               err_to_q, err_to_d;
    logic               err_nl_q, err_nl_d;
    logic               err_ov_q, err_ov_d;

    logic               w_cmd_ok;
    logic               w_disp;
    logic [OP_W-1:0]    w_disp_op;
    logic               w_wd_en;
    logic               w_wd_clr;
    logic               w_wd_exp;

    // Commands with op 0/7 are silently ignored at intake.
    assign w_cmd_ok = cmd_valid &&
                      (is_read_op(32'(cmd_op)) || is_compute_op(32'(cmd_op)));

    assign w_wd_en  = (state_q == START) || (state_q == RUN) || (state_q == WAIT_TX);
    assign w_wd_clr = (state_d != state_q);

    seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_wd_clr),
        .enable_i  (w_wd_en),
        .expired_o (w_wd_exp)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_op_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_op_q  <= '0;
            res_q      <= '0;
            res_seen_q <= 1'b0;
            tx_data_q  <= '0;
            tx_op_q    <= '0;
            a_ok_q     <= 1'b0;
            b_ok_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_nl_q   <= 1'b0;
            err_ov_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_op_q   <= cur_op_d;
            pend_vld_q <= pend_vld_d;
            pend_op_q  <= pend_op_d;
            res_q      <= res_d;
            res_seen_q <= res_seen_d;
            tx_data_q  <= tx_data_d;
            tx_op_q    <= tx_op_d;
            a_ok_q     <= a_ok_d;
            b_ok_q     <= b_ok_d;
            err_to_q   <= err_to_d;
            err_nl_q   <= err_nl_d;
            err_ov_q   <= err_ov_d;
        end
    end

    // Next-state: command intake, dispatch, core handshake and TX handoff.
    always_comb begin
        state_d    = state_q;
        cur_op_d   = cur_op_q;
        pend_vld_d = pend_vld_q;
        pend_op_d  = pend_op_q;
        res_d      = res_q;
        res_seen_d = res_seen_q;
        tx_data_d  = tx_data_q;
        tx_op_d    = tx_op_q;
        a_ok_d     = a_ok_q | vec_a_loaded;
        b_ok_d     = b_ok_q | vec_b_loaded;
        err_to_d   = err_to_q;
        err_nl_d   = err_nl_q;
        err_ov_d   = err_ov_q;
        w_disp     = 1'b0;
        w_disp_op  = cmd_op;

        if (state_q == IDLE) begin
            // Slot head has priority; a new command refills the freed slot.
            if (pend_vld_q) begin
                w_disp     = 1'b1;
                w_disp_op  = pend_op_q;
                pend_vld_d = w_cmd_ok;
                if (w_cmd_ok) begin
                    pend_op_d = cmd_op;
                end
            end else if (w_cmd_ok) begin
                w_disp    = 1'b1;
                w_disp_op = cmd_op;
            end
        end else if (w_cmd_ok) begin
            if (pend_vld_q) begin
                err_ov_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_op_d  = cmd_op;
            end
        end

        case (state_q)
            IDLE: begin
                if (w_disp) begin
                    if (is_read_op(32'(w_disp_op))) begin
                        cur_op_d  = w_disp_op;
                        tx_op_d   = w_disp_op;
                        tx_data_d = '0;
                        state_d   = SEND;
                    end else if (!(a_ok_q && b_ok_q)) begin
                        err_nl_d = 1'b1;
                    end else begin
                        cur_op_d = w_disp_op;
                        state_d  = ap_idle ? START : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (ap_idle) begin
                    state_d = START;
                end
            end
            START: begin
                if (ap_ready) begin
                    res_seen_d = 1'b0;
                    state_d    = RUN;
                end else if (w_wd_exp) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (res_vld && !res_seen_q) begin
                    res_d      = res_data;
                    res_seen_d = 1'b1;
                end
                if (ap_done) begin
                    // Send the first result of the run, or 0 if the core gave none.
                    if (res_seen_q) begin
                        tx_data_d = res_q;
                    end else if (res_vld) begin
                        tx_data_d = res_data;
                    end else begin
                        tx_data_d = '0;
                    end
                    tx_op_d = cur_op_q;
                    state_d = SEND;
                end else if (w_wd_exp) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end else if (w_wd_exp) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so reset clears them at once.
    always_comb begin
        ap_start    = (state_q == START);
        tx_start    = (state_q == SEND);
        tx_op       = tx_op_q;
        tx_data     = tx_data_q;
        busy        = (state_q != IDLE) || pend_vld_q;
        err_timeout = err_to_q;
        err_noload  = err_nl_q;
        err_overrun = err_ov_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hls_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_hls_op_sequencer                                    |
// | Purpose : Directed self-checking bench for hls_op_sequencer.     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_hls_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic        vec_a_loaded, vec_b_loaded;
    logic        ap_ready, ap_idle, ap_done, res_vld;
    logic [31:0] res_data;
    logic        tx_done;

    logic        ap_start, tx_start, busy, err_timeout, err_noload, err_overrun;
    logic [2:0]  tx_op;
    logic [31:0] tx_data;

    logic        w_ap_start, w_tx_start, w_busy, w_err_timeout, w_err_noload, w_err_overrun;
    logic [2:0]  w_tx_op;
    logic [31:0] w_tx_data;

    int checks;
    int errors;

    hls_op_sequencer #(.RES_W(32), .OP_W(3), .TIMEOUT_CYC(65536)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .vec_a_loaded(vec_a_loaded), .vec_b_loaded(vec_b_loaded),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .res_vld(res_vld), .res_data(res_data),
        .tx_start(tx_start), .tx_op(tx_op), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .err_timeout(err_timeout), .err_noload(err_noload), .err_overrun(err_overrun)
    );

    hls_op_sequencer #(.RES_W(32), .OP_W(3), .TIMEOUT_CYC(16)) dut_wd (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .vec_a_loaded(vec_a_loaded), .vec_b_loaded(vec_b_loaded),
        .ap_start(w_ap_start), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .res_vld(res_vld), .res_data(res_data),
        .tx_start(w_tx_start), .tx_op(w_tx_op), .tx_data(w_tx_data), .tx_done(tx_done),
        .busy(w_busy), .err_timeout(w_err_timeout), .err_noload(w_err_noload), .err_overrun(w_err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd_op = 0; vec_a_loaded = 0; vec_b_loaded = 0;
        ap_ready = 0; ap_idle = 1; ap_done = 0; res_vld = 0; res_data = 0; tx_done = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic load_vectors();
        vec_a_loaded = 1; vec_b_loaded = 1;
        tick();
        vec_a_loaded = 0; vec_b_loaded = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        tick();
        checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL reset_ap_start got %b want 0", ap_start); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
        checks++; if (tx_op !== 3'd0) begin errors++; $display("FAIL reset_tx_op got %0d want 0", tx_op); end
        checks++; if ({busy, err_timeout, err_noload, err_overrun} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, err_timeout, err_noload, err_overrun}); end
        rst = 0;
    endtask

    task automatic test_compute();
        int starts;
        int sends;
        apply_reset();
        load_vectors();
        cmd_valid = 1; cmd_op = 3'd6;
        tick();                                   // cycle 1
        cmd_valid = 0;
        checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL c1_ap_start_cyc1 got %b want 1", ap_start); end
        tick();                                   // cycle 2
        checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL c1_ap_start_cyc2 got %b want 1", ap_start); end
        ap_ready = 1; ap_idle = 0;
        tick();                                   // cycle 3, RUN
        ap_ready = 0;
        checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL c1_ap_start_cyc3 got %b want 0", ap_start); end
        starts = 0; sends = 0;
        for (int c = 4; c <= 40; c++) begin
            tick();
            if (ap_start) starts++;
            if (tx_start) sends++;
        end
        checks++; if (starts + sends !== 0) begin errors++; $display("FAIL c1_quiet_run got %0d pulses want 0", starts + sends); end
        res_vld = 1; res_data = 32'h0000_1234; ap_done = 1;
        tick();                                   // cycle 41, SEND
        res_vld = 0; res_data = 32'hDEAD_BEEF; ap_done = 0; ap_idle = 1;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL c1_tx_start got %b want 1", tx_start); end
        checks++; if (tx_data !== 32'h0000_1234) begin errors++; $display("FAIL c1_tx_data got %h want 00001234", tx_data); end
        checks++; if (tx_op !== 3'd6) begin errors++; $display("FAIL c1_tx_op got %0d want 6", tx_op); end
        tick();                                   // WAIT_TX
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL c1_tx_start_once got %b want 0", tx_start); end
        checks++; if (tx_data !== 32'h0000_1234) begin errors++; $display("FAIL c1_tx_data_hold got %h want 00001234", tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c1_busy_wait_tx got %b want 1", busy); end
        tx_done = 1;
        tick();
        tx_done = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c1_busy_after_done got %b want 0", busy); end
    endtask

    task automatic test_noload();
        apply_reset();
        vec_a_loaded = 1;
        tick();
        vec_a_loaded = 0;
        cmd_valid = 1; cmd_op = 3'd3;
        tick();
        cmd_valid = 0;
        checks++; if (err_noload !== 1'b1) begin errors++; $display("FAIL nl_err got %b want 1", err_noload); end
        checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL nl_ap_start got %b want 0", ap_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nl_busy got %b want 0", busy); end
        tick();
        tick();
        checks++; if ({ap_start, busy, tx_start} !== 3'b000) begin errors++;
            $display("FAIL nl_stay_idle got %b want 000", {ap_start, busy, tx_start}); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        load_vectors();
        cmd_valid = 1; cmd_op = 3'd6;
        tick();                                   // START
        cmd_valid = 0; ap_ready = 1; ap_idle = 0;
        tick();                                   // RUN
        ap_ready = 0;
        cmd_valid = 1; cmd_op = 3'd5;
        tick();
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", err_overrun); end
        cmd_op = 3'd4;
        tick();
        cmd_valid = 0;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", err_overrun); end
        res_vld = 1; res_data = 32'h55; ap_done = 1;
        tick();                                   // SEND op 6
        res_vld = 0; ap_done = 0; ap_idle = 1;
        checks++; if (tx_op !== 3'd6 || tx_data !== 32'h55) begin errors++;
            $display("FAIL b2b_first_send got op %0d data %h want op 6 data 00000055", tx_op, tx_data); end
        tick();                                   // WAIT_TX
        tx_done = 1;
        tick();                                   // IDLE, slot full
        tx_done = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_slot got %b want 1", busy); end
        tick();                                   // slot served -> START
        checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL b2b_slot_start got %b want 1", ap_start); end
        ap_ready = 1;
        tick();                                   // RUN
        ap_ready = 0;
        res_vld = 1; res_data = 32'h77; ap_done = 1;
        tick();                                   // SEND op 5
        res_vld = 0; ap_done = 0;
        checks++; if (tx_op !== 3'd5 || tx_data !== 32'h77) begin errors++;
            $display("FAIL b2b_second_send got op %0d data %h want op 5 data 00000077", tx_op, tx_data); end
        tick();
        tx_done = 1;
        tick();
        tx_done = 0;
        tick();
        checks++; if ({busy, ap_start, tx_start} !== 3'b000) begin errors++;
            $display("FAIL b2b_drained got %b want 000", {busy, ap_start, tx_start}); end
    endtask

    task automatic test_read_op();
        // Follows the back-to-back test with no reset so tx_data starts nonzero.
        cmd_valid = 1; cmd_op = 3'd1;
        tick();
        cmd_valid = 0;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rd_tx_start got %b want 1", tx_start); end
        checks++; if (tx_op !== 3'd1) begin errors++; $display("FAIL rd_tx_op got %0d want 1", tx_op); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL rd_tx_data got %h want 0", tx_data); end
        checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL rd_ap_start got %b want 0", ap_start); end
        tick();
        tx_done = 1;
        tick();
        tx_done = 0;
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        load_vectors();
        cmd_valid = 1; cmd_op = 3'd6;
        tick();                                   // START
        cmd_valid = 0; ap_ready = 1; ap_idle = 0;
        tick();                                   // RUN cycle 1
        ap_ready = 0;
        early = 0;
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (w_err_timeout || !w_busy) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL wd_early got %0d want 0", early); end
        tick();
        checks++; if (w_err_timeout !== 1'b1) begin errors++; $display("FAIL wd_err got %b want 1", w_err_timeout); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL wd_idle got %b want 0", w_busy); end
        cmd_valid = 1; cmd_op = 3'd6;
        tick();                                   // WAIT_IDLE
        cmd_valid = 0;
        tick();
        tick();
        checks++; if (w_ap_start !== 1'b0 || w_busy !== 1'b1) begin errors++;
            $display("FAIL wd_wait_idle got start %b busy %b want 0 1", w_ap_start, w_busy); end
        ap_idle = 1;
        tick();
        checks++; if (w_ap_start !== 1'b1) begin errors++; $display("FAIL wd_start_after_idle got %b want 1", w_ap_start); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        load_vectors();
        cmd_valid = 1; cmd_op = 3'd1;
        tick();                                   // SEND
        cmd_valid = 0;
        tick();                                   // WAIT_TX
        cmd_valid = 1; cmd_op = 3'd2;
        tick();                                   // queued
        cmd_op = 3'd3;
        tick();                                   // dropped
        cmd_valid = 0;
        checks++; if (tx_op !== 3'd1 || busy !== 1'b1 || err_overrun !== 1'b1) begin errors++;
            $display("FAIL mr_pre got op %0d busy %b ovr %b want 1 1 1", tx_op, busy, err_overrun); end
        #2 rst = 1;
        #1;
        checks++; if ({tx_op, busy, err_overrun, tx_start, ap_start} !== 7'b0) begin errors++;
            $display("FAIL mr_async got %b want 0", {tx_op, busy, err_overrun, tx_start, ap_start}); end
        @(posedge clk);
        #1 rst = 0;
        tx_done = 1;
        tick();
        tx_done = 0;
        tick();
        checks++; if ({busy, tx_start} !== 2'b00) begin errors++;
            $display("FAIL mr_slot_empty got %b want 00", {busy, tx_start}); end
        ap_idle = 1;
        cmd_valid = 1; cmd_op = 3'd6;
        tick();
        cmd_valid = 0;
        checks++; if (err_noload !== 1'b1 || ap_start !== 1'b0) begin errors++;
            $display("FAIL mr_flags_cleared got noload %b start %b want 1 0", err_noload, ap_start); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_compute();
        test_noload();
        test_back_to_back();
        test_read_op();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
